// File: rtl/pb_input_port.sv
`default_nettype none
// ============================================================================
// Module   : pb_input_port
// Brief    : Synchronised, debounced push-button port with sticky press events.
//            Define PB_IRQ_EN to add the MASK register and the irq output.
// Revision : 1.0 - initial release
// ============================================================================
module pb_input_port #(
    parameter int NUM_PB          = 4,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_PB-1:0] pb_n,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [1:0]        addr,
    input  logic [7:0]        wr_data,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              irq
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_PB-1:0] sync1_q;
    logic [NUM_PB-1:0] sync2_q;
    logic [NUM_PB-1:0] sample;
    logic [NUM_PB-1:0] stable_q, stable_d;
    logic [CW-1:0]     cnt_q [NUM_PB];
    logic [CW-1:0]     cnt_d [NUM_PB];
    logic [NUM_PB-1:0] rise;
    logic [NUM_PB-1:0] event_q, event_d;
    logic [NUM_PB-1:0] mask;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              event_rd;
    logic              unused_wr_bits;

    assign sample         = ~sync2_q;
    assign unused_wr_bits = ^{wr_en, wr_data};

    // Any sample that agrees with the accepted level restarts the count.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NUM_PB; i++) begin
            cnt_d[i] = '0;
            if (sample[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sample[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // A press landing on the clearing read is returned and also kept.
    always_comb begin
        rise       = stable_d & ~stable_q;
        event_rd   = rd_en && (addr == 2'd1);
        event_d    = event_rd ? rise : (event_q | rise);
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_data_d = '0;
            case (addr)
                2'd0:    rd_data_d[NUM_PB-1:0] = stable_q;
                2'd1:    rd_data_d[NUM_PB-1:0] = event_q | rise;
                2'd2:    rd_data_d[NUM_PB-1:0] = mask;
                default: rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            stable_q   <= '0;
            for (int i = 0; i < NUM_PB; i++) begin
                cnt_q[i] <= '0;
            end
            event_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            sync1_q    <= pb_n;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            event_q    <= event_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

`ifdef PB_IRQ_EN
    logic [NUM_PB-1:0] mask_q, mask_d;
    logic              irq_q, irq_d;

    always_comb begin
        mask_d = mask_q;
        if (wr_en && (addr == 2'd2)) begin
            mask_d = wr_data[NUM_PB-1:0];
        end
        irq_d = |(event_q & mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign mask = mask_q;
    assign irq  = irq_q;
`else
    assign mask = '0;
    assign irq  = 1'b0;
`endif

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pb_input_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_pb_input_port
// Brief    : Scoreboarded bench for pb_input_port (NUM_PB=4, DEBOUNCE_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pb_input_port;
    localparam int NPB = 4;
    localparam int DEB = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [NPB-1:0] pb_n;
    logic           rd_en;
    logic           wr_en;
    logic [1:0]     addr;
    logic [7:0]     wr_data;
    logic [7:0]     rd_data;
    logic           rd_valid;
    logic           irq;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp;

    always #5 clk = ~clk;

    pb_input_port #(
        .NUM_PB          (NPB),
        .DEBOUNCE_CYCLES (DEB)
    ) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .pb_n     (pb_n),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .irq      (irq)
    );

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic launch_read(input logic [1:0] a, input logic [7:0] e);
        rd_en = 1'b1;
        addr  = a;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; pb_n = '1; rd_en = 1'b0; wr_en = 1'b0; addr = 2'd0; wr_data = 8'h00;
        idle(3);
        reset_n = 1'b1;
        pb_n = 4'b1110;
        idle(3);
        launch_read(2'd0, 8'h00);
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++;
            $display("FAIL rst_pre_read: rd_data=%h rd_valid=%b, want %h valid 1", rd_data, rd_valid, exp);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rd_data, rd_valid, irq} !== 10'h000) begin
            errors++;
            $display("FAIL rst_outputs: rd_data=%h rd_valid=%b irq=%b, want all 0", rd_data, rd_valid, irq);
        end
        rd_en = 1'b0;
        idle(2);
        reset_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            launch_read(2'd0, (k >= 3 + DEB) ? 8'h01 : 8'h00);
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                errors++;
                $display("FAIL rst_level k=%0d: rd_data=%h rd_valid=%b, want %h valid 1", k, rd_data, rd_valid, exp);
            end
        end
        rd_en = 1'b0;
        pb_n  = '1;
        idle(8);
        launch_read(2'd1, 8'h01);
        @(negedge clk);
        launch_read(2'd1, 8'h00);
        exp = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++;
            $display("FAIL rst_event: rd_data=%h, want %h", rd_data, exp);
        end
        @(negedge clk);
        rd_en = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++;
            $display("FAIL rst_event_clr: rd_data=%h, want %h", rd_data, exp);
        end
    endtask

    task automatic test_debounce();
        pb_n = 4'b1110;
        for (int k = 1; k <= 10; k++) begin
            if (k == 4) pb_n = '1;
            launch_read(2'd0, 8'h00);
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                errors++;
                $display("FAIL glitch_level k=%0d: rd_data=%h, want %h", k, rd_data, exp);
            end
        end
        launch_read(2'd1, 8'h00);
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++;
            $display("FAIL glitch_event: rd_data=%h, want %h", rd_data, exp);
        end
        pb_n = 4'b1110;
        for (int k = 1; k <= 8; k++) begin
            launch_read(2'd0, (k >= 3 + DEB) ? 8'h01 : 8'h00);
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                errors++;
                $display("FAIL press_level k=%0d: rd_data=%h, want %h", k, rd_data, exp);
            end
        end
        pb_n = '1;
        for (int k = 1; k <= 8; k++) begin
            launch_read(2'd0, (k >= 3 + DEB) ? 8'h00 : 8'h01);
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                errors++;
                $display("FAIL release_level k=%0d: rd_data=%h, want %h", k, rd_data, exp);
            end
        end
        launch_read(2'd1, 8'h01);
        @(negedge clk);
        rd_en = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++;
            $display("FAIL hold_event: rd_data=%h, want %h", rd_data, exp);
        end
    endtask

    task automatic test_event();
        pb_n = 4'b1011;
        idle(8);
        pb_n = '1;
        idle(8);
        launch_read(2'd1, 8'h04);
        @(negedge clk);
        rd_en = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++;
            $display("FAIL event_pb2: rd_data=%h rd_valid=%b, want %h valid 1", rd_data, rd_valid, exp);
        end
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h04) begin
            errors++;
            $display("FAIL rd_hold: rd_data=%h rd_valid=%b, want 04 valid 0", rd_data, rd_valid);
        end
        launch_read(2'd1, 8'h00);
        @(negedge clk);
        rd_en = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++;
            $display("FAIL event_cleared: rd_data=%h, want %h", rd_data, exp);
        end
        pb_n = 4'b0101;
        idle(8);
        launch_read(2'd0, 8'h0A);
        @(negedge clk);
        launch_read(2'd1, 8'h0A);
        exp = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++;
            $display("FAIL level_multi: rd_data=%h, want %h", rd_data, exp);
        end
        @(negedge clk);
        launch_read(2'd3, 8'h00);
        exp = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++;
            $display("FAIL event_multi: rd_data=%h, want %h", rd_data, exp);
        end
        @(negedge clk);
        rd_en = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++;
            $display("FAIL addr3: rd_data=%h, want %h", rd_data, exp);
        end
        pb_n = '1;
        idle(8);
        launch_read(2'd1, 8'h00);
        @(negedge clk);
        rd_en = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++;
            $display("FAIL release_no_event: rd_data=%h, want %h", rd_data, exp);
        end
    endtask

    task automatic test_set_vs_clear();
        pb_n = 4'b1110;
        idle(8);
        pb_n = '1;
        idle(8);
        // PB1 reaches stable on edge 2+DEB after the pin edge; the read is sampled on that edge.
        pb_n = 4'b1101;
        idle(1 + DEB);
        launch_read(2'd1, 8'h03);
        @(negedge clk);
        launch_read(2'd1, 8'h02);
        exp = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++;
            $display("FAIL setclr_same_edge: rd_data=%h, want %h", rd_data, exp);
        end
        @(negedge clk);
        rd_en = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++;
            $display("FAIL setclr_kept: rd_data=%h, want %h", rd_data, exp);
        end
        pb_n = '1;
        idle(8);
    endtask

    task automatic test_chatter();
        for (int k = 0; k < 40; k++) begin
            pb_n = (((k / 2) % 2) == 0) ? 4'b0111 : 4'b1111;
            launch_read(2'd0, 8'h00);
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                errors++;
                $display("FAIL chatter_level k=%0d: rd_data=%h, want %h", k, rd_data, exp);
            end
        end
        rd_en = 1'b0;
        pb_n  = '1;
        idle(8);
        launch_read(2'd1, 8'h00);
        @(negedge clk);
        rd_en = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++;
            $display("FAIL chatter_event: rd_data=%h, want %h", rd_data, exp);
        end
    endtask

`ifdef PB_IRQ_EN
    task automatic test_irq();
        wr_en = 1'b1; wr_data = 8'h02;
        launch_read(2'd2, 8'h00);
        @(negedge clk);
        wr_en = 1'b0;
        launch_read(2'd2, 8'h02);
        exp = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++;
            $display("FAIL mask_rw_same: rd_data=%h, want %h", rd_data, exp);
        end
        @(negedge clk);
        rd_en = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++;
            $display("FAIL mask_readback: rd_data=%h, want %h", rd_data, exp);
        end
        wr_en = 1'b1; addr = 2'd0; wr_data = 8'hFF;
        @(negedge clk);
        wr_en = 1'b0;
        launch_read(2'd2, 8'h02);
        @(negedge clk);
        rd_en = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++;
            $display("FAIL mask_wr_ignored: rd_data=%h, want %h", rd_data, exp);
        end
        pb_n = 4'b1110;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL irq_masked k=%0d: irq=%b, want 0", k, irq);
            end
        end
        pb_n = '1;
        idle(8);
        pb_n = 4'b1101;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (irq !== (k >= 3 + DEB)) begin
                errors++;
                $display("FAIL irq_rise k=%0d: irq=%b, want %b", k, irq, (k >= 3 + DEB));
            end
        end
        launch_read(2'd1, 8'h03);
        @(negedge clk);
        rd_en = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp || irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_event: rd_data=%h irq=%b, want %h irq 1", rd_data, irq, exp);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_fall_read: irq=%b, want 0", irq);
        end
        pb_n = '1;
        idle(8);
        pb_n = 4'b1101;
        idle(8);
        wr_en = 1'b1; addr = 2'd2; wr_data = 8'h00;
        @(negedge clk);
        wr_en = 1'b0;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_before_mask: irq=%b, want 1", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_fall_mask: irq=%b, want 0", irq);
        end
        pb_n = '1;
        idle(8);
        launch_read(2'd1, 8'h02);
        @(negedge clk);
        rd_en = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++;
            $display("FAIL irq_event2: rd_data=%h, want %h", rd_data, exp);
        end
    endtask
`else
    task automatic test_irq();
        wr_en = 1'b1; addr = 2'd2; wr_data = 8'h02;
        @(negedge clk);
        wr_en = 1'b0;
        launch_read(2'd2, 8'h00);
        @(negedge clk);
        rd_en = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++;
            $display("FAIL mask_absent: rd_data=%h, want %h", rd_data, exp);
        end
        pb_n = 4'b1101;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL irq_tied k=%0d: irq=%b, want 0", k, irq);
            end
        end
        pb_n = '1;
        idle(8);
        launch_read(2'd1, 8'h02);
        @(negedge clk);
        rd_en = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp || irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_tied_event: rd_data=%h irq=%b, want %h irq 0", rd_data, irq, exp);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_debounce();
        test_event();
        test_set_vs_clear();
        test_chatter();
        test_irq();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
